tx_frame_arb: RTL

- Packet-atomic arbiter for the Ethernet transmit path.
- Shares one 16-bit MAC TX stream between two packet sources: the ARP generator (request/reply frames, 21 beats each) and the IP/UDP frame builder.
- Grants whole frames (sop..eop) using round-robin selection, honours downstream rdy backpressure, and inserts a programmable inter-frame idle gap.
- Sits between the tx_arp / tx_ip sources and the MAC TX interface.

---
 rtl/tx_frame_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tx_frame_arb.sv
// tx_frame_arb -- packet-atomic two-source arbiter for the Ethernet TX path.
//
// Shares one MAC TX stream between the ARP generator and the IP/UDP frame
// builder. Whole frames (sop..eop) are granted round-robin, the granted
// source is passed straight through with zero added latency, and a
// programmable idle gap follows every output eop.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   arp_data/vld/sop/eop/mty      ARP source beat;  arp_rdy accepts it
//   ip_data/vld/sop/eop/mty       IP source beat;   ip_rdy accepts it
//   tx_data/vld/sop/eop/mty       output stream toward the MAC
//   tx_rdy                        downstream ready
//   drop_cnt                      saturating count of non-sop beats
//                                 discarded while idle
module tx_frame_arb #(
  parameter int DATA_W  = 16,
  parameter int GAP_CYC = 6,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] arp_data,
  input  logic              arp_vld,
  input  logic              arp_sop,
  input  logic              arp_eop,
  input  logic              arp_mty,
  output logic              arp_rdy,
  input  logic [DATA_W-1:0] ip_data,
  input  logic              ip_vld,
  input  logic              ip_sop,
  input  logic              ip_eop,
  input  logic              ip_mty,
  output logic              ip_rdy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_vld,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              tx_mty,
  input  logic              tx_rdy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, ARP, IP, GAP} state_t;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t           state;
  logic             rr_last;   // 1: IP was granted last, 0: ARP was
  logic [GAP_W-1:0] gap_cnt;

  logic       arp_req, ip_req;
  logic       grant_arp, grant_ip;
  logic       arp_drop, ip_drop;
  logic [1:0] drop_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign arp_req = arp_vld && arp_sop;
  assign ip_req  = ip_vld && ip_sop;

  // On a tie the source that was not served last wins.
  assign grant_ip  = ip_req && (!arp_req || !rr_last);
  assign grant_arp = arp_req && !grant_ip;

  // A source presenting sop is never flushed, only mid-frame debris.
  assign arp_drop = (state == IDLE) && arp_vld && !arp_sop;
  assign ip_drop  = (state == IDLE) && ip_vld && !ip_sop;
  assign drop_inc = {1'b0, arp_drop} + {1'b0, ip_drop};

  always_comb begin
    arp_rdy = 1'b0;
    ip_rdy  = 1'b0;
    tx_data = '0;
    tx_vld  = 1'b0;
    tx_sop  = 1'b0;
    tx_eop  = 1'b0;
    tx_mty  = 1'b0;
    case (state)
      IDLE: begin
        // Flush handshake is masked so every output reads 0 during reset.
        arp_rdy = rst_n && arp_drop;
        ip_rdy  = rst_n && ip_drop;
      end
      ARP: begin
        tx_data = arp_data;
        tx_vld  = arp_vld;
        tx_sop  = arp_sop;
        tx_eop  = arp_eop;
        tx_mty  = arp_mty;
        arp_rdy = tx_rdy;
      end
      IP: begin
        tx_data = ip_data;
        tx_vld  = ip_vld;
        tx_sop  = ip_sop;
        tx_eop  = ip_eop;
        tx_mty  = ip_mty;
        ip_rdy  = tx_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      gap_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          drop_cnt <= sat_add(drop_cnt, drop_inc);
          if (grant_arp) begin
            state   <= ARP;
            rr_last <= 1'b0;
          end else if (grant_ip) begin
            state   <= IP;
            rr_last <= 1'b1;
          end
        end
        ARP, IP: begin
          if ((state == ARP) ? (arp_vld && tx_rdy && arp_eop)
                             : (ip_vld && tx_rdy && ip_eop)) begin
            if (GAP_CYC > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
